// File: rtl/alu_issue_if.sv
// alu_issue_if: command and response handshake bundle between a producer and alu_issue_ctrl
interface alu_issue_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [OPW-1:0]   cmd_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_err;
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_y, rsp_err
    );
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        output cmd_ready, rsp_valid, rsp_y, rsp_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: buffers ALU commands in a FIFO, issues them one at a time from registers and
// returns each captured result (or an illegal-opcode error) on a valid/ready response port.
module alu_issue_ctrl #(
    parameter int WIDTH  = 8,
    parameter int OPW    = 4,
    parameter int MAX_OP = 8,
    parameter int DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_if.slave       bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_f,
    input  logic [WIDTH-1:0] alu_y,
    output logic [15:0]      done_cnt
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
    state_t state, state_n;
    logic [2*WIDTH+OPW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [WIDTH-1:0] head_a, head_b;
    logic [OPW-1:0] head_op;
    logic full, empty, push, pop, hs, legal;

    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign bus.cmd_ready = !full && !rst;
    assign push = bus.cmd_valid && bus.cmd_ready;
    assign hs = bus.rsp_valid && bus.rsp_ready;
    assign {head_a, head_b, head_op} = mem[rd_ptr];
    assign legal = 32'(head_op) <= MAX_OP;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    // A pop happens from IDLE, or from HOLD on the handshake edge for back-to-back issue
    always_comb begin
        pop = !empty && (state == IDLE || (state == HOLD && hs));
        state_n = pop ? (legal ? EXEC : HOLD) : state == EXEC ? HOLD : (state == HOLD && hs) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            alu_a <= '0;
            alu_b <= '0;
            alu_f <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_y <= '0;
            bus.rsp_err <= 1'b0;
            done_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (hs)
                done_cnt <= done_cnt + 16'd1;
            // Illegal opcodes never reach the ALU: the error response is posted straight away
            if (pop && legal) begin
                alu_a <= head_a;
                alu_b <= head_b;
                alu_f <= head_op;
                bus.rsp_valid <= 1'b0;
            end else if (pop) begin
                bus.rsp_y <= '0;
                bus.rsp_err <= 1'b1;
                bus.rsp_valid <= 1'b1;
            end else if (state == EXEC) begin
                bus.rsp_y <= alu_y;
                bus.rsp_err <= 1'b0;
                bus.rsp_valid <= 1'b1;
            end else if (hs) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: vector table, timing sequences and a randomized run checked against
// a queue-based reference model of the issue controller with a behavioural ALU attached.
module tb_alu_issue_ctrl;
    localparam int MAX_OP = 8;
    localparam int NW = 65536 - 20 + 5;
    typedef struct packed {logic [7:0] y; logic err;} rsp_t;
    typedef struct {logic [7:0] a; logic [7:0] b; logic [3:0] op; logic [7:0] y; logic err;} vec_t;

    logic clk = 0;
    logic rst = 1;
    logic [7:0] alu_a, alu_b, alu_y;
    logic [3:0] alu_f;
    logic [15:0] done_cnt;
    int n_chk = 0;
    int n_fail = 0;
    int exp_done = 0;
    int cyc = 0;
    bit seen_rst = 0;
    bit hold_pend = 0;
    bit rnd_on = 0;
    logic [7:0] hold_y;
    logic hold_err;
    rsp_t m_e;
    rsp_t exp_q[$];
    int hs_t[$];
    vec_t tbl[12];

    alu_issue_if bus();

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ~a;
            4'd6: return a << 1;
            4'd7: return a >> 1;
            4'd8: return b;
            default: return 8'hEE;
        endcase
    endfunction

    assign alu_y = alu_fn(alu_a, alu_b, alu_f);

    function automatic rsp_t ref_rsp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        rsp_t r;
        if (int'(op) > MAX_OP) r = {8'h00, 1'b1};
        else r = {alu_fn(a, b, op), 1'b0};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        int n = 0;
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.cmd_op = op;
        bus.cmd_valid = 1;
        @(negedge clk);
        while (!bus.cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", 32'(bus.cmd_ready), 1);
        @(posedge clk);
        #1 bus.cmd_valid = 0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_wait", 32'(bus.rsp_valid), 1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || bus.rsp_valid) && n < budget);
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Reference model: every accepted command queues its expected response; handshakes retire them
    initial forever begin
        @(negedge clk);
        if (seen_rst) begin
            chk("done_cnt", 32'(done_cnt), exp_done & 'hFFFF);
            if (hold_pend) begin
                chk("hold_valid", 32'(bus.rsp_valid), 1);
                chk("hold_y", 32'(bus.rsp_y), 32'(hold_y));
                chk("hold_err", 32'(bus.rsp_err), 32'(hold_err));
            end
            if (exp_q.size() > 4) chk("ready_when_full", 32'(bus.cmd_ready), 0);
        end
        hold_pend = 0;
        if (rst) begin
            seen_rst = 1;
            exp_q.delete();
            exp_done = 0;
        end else begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rsp_extra: response y=0x%0h with nothing outstanding", bus.rsp_y);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("rsp_y", 32'(bus.rsp_y), 32'(m_e.y));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(m_e.err));
                end
                exp_done++;
                hs_t.push_back(cyc);
            end else if (bus.rsp_valid) begin
                hold_pend = 1;
                hold_y = bus.rsp_y;
                hold_err = bus.rsp_err;
            end
            if (bus.cmd_valid && bus.cmd_ready)
                exp_q.push_back(ref_rsp(bus.cmd_a, bus.cmd_b, bus.cmd_op));
        end
    end

    initial begin
        logic [7:0] last_a, last_b;
        logic [3:0] last_f;
        rsp_t first;
        int n, k;
        tbl[0]  = '{8'h6B, 8'h4A, 4'd0, 8'hB5, 1'b0};
        tbl[1]  = '{8'h6B, 8'h4A, 4'd1, 8'h21, 1'b0};
        tbl[2]  = '{8'h6B, 8'h4A, 4'd2, 8'h4A, 1'b0};
        tbl[3]  = '{8'h6B, 8'h4A, 4'd3, 8'h6B, 1'b0};
        tbl[4]  = '{8'h6B, 8'h4A, 4'd4, 8'h21, 1'b0};
        tbl[5]  = '{8'h6B, 8'h4A, 4'd5, 8'h94, 1'b0};
        tbl[6]  = '{8'h6B, 8'h4A, 4'd6, 8'hD6, 1'b0};
        tbl[7]  = '{8'h6B, 8'h4A, 4'd7, 8'h35, 1'b0};
        tbl[8]  = '{8'h6B, 8'h4A, 4'd8, 8'h4A, 1'b0};
        tbl[9]  = '{8'h11, 8'h22, 4'd9, 8'h00, 1'b1};
        tbl[10] = '{8'h33, 8'h44, 4'hF, 8'h00, 1'b1};
        tbl[11] = '{8'hFF, 8'h01, 4'd0, 8'h00, 1'b0};
        bus.cmd_valid = 0;
        bus.cmd_a = 0;
        bus.cmd_b = 0;
        bus.cmd_op = 0;
        bus.rsp_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset in the middle of traffic
        send(8'h12, 8'h34, 4'd3);
        send(8'h56, 8'h78, 4'd1);
        send(8'h9A, 8'hBC, 4'd7);
        rst = 1;
        @(negedge clk);
        chk("rst_ready_low", 32'(bus.cmd_ready), 0);
        @(negedge clk);
        chk("rst_ready", 32'(bus.cmd_ready), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_alu_b", 32'(alu_b), 0);
        chk("rst_alu_f", 32'(alu_f), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_y", 32'(bus.rsp_y), 0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 0);
        chk("rst_done_cnt", 32'(done_cnt), 0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.cmd_ready), 1);
        chk("post_rst_valid", 32'(bus.rsp_valid), 0);
        @(posedge clk);
        #1;

        // Single command latency
        bus.cmd_a = 8'h6B;
        bus.cmd_b = 8'h4A;
        bus.cmd_op = 4'd0;
        bus.cmd_valid = 1;
        bus.rsp_ready = 1;
        @(negedge clk);
        chk("single_ready", 32'(bus.cmd_ready), 1);
        @(posedge clk);
        #1 bus.cmd_valid = 0;
        @(negedge clk);
        chk("single_t0_valid", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        chk("single_alu_a", 32'(alu_a), 'h6B);
        chk("single_alu_b", 32'(alu_b), 'h4A);
        chk("single_alu_f", 32'(alu_f), 0);
        chk("single_t1_valid", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        chk("single_t2_valid", 32'(bus.rsp_valid), 1);
        chk("single_y", 32'(bus.rsp_y), 32'(alu_fn(8'h6B, 8'h4A, 4'd0)));
        chk("single_err", 32'(bus.rsp_err), 0);
        @(negedge clk);
        chk("single_done", 32'(done_cnt), 1);
        chk("single_valid_drop", 32'(bus.rsp_valid), 0);
        @(posedge clk);
        #1;

        // Opcode sweep plus illegal opcodes, one command at a time
        last_a = 8'h6B;
        last_b = 8'h4A;
        last_f = 4'd0;
        for (int i = 0; i < 12; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].op);
            wait_rsp();
            chk($sformatf("vec%0d_y", i), 32'(bus.rsp_y), 32'(tbl[i].y));
            chk($sformatf("vec%0d_err", i), 32'(bus.rsp_err), 32'(tbl[i].err));
            if (!tbl[i].err) begin
                last_a = tbl[i].a;
                last_b = tbl[i].b;
                last_f = tbl[i].op;
            end
            chk($sformatf("vec%0d_alu_a", i), 32'(alu_a), 32'(last_a));
            chk($sformatf("vec%0d_alu_b", i), 32'(alu_b), 32'(last_b));
            chk($sformatf("vec%0d_alu_f", i), 32'(alu_f), 32'(last_f));
            @(posedge clk);
            #1;
        end

        // Back-to-back sweep: one result every two clocks
        hs_t.delete();
        for (int i = 0; i < 9; i++) send(tbl[i].a, tbl[i].b, tbl[i].op);
        drain(100);
        chk("burst_count", hs_t.size(), 9);
        for (int i = 1; i < hs_t.size(); i++) chk($sformatf("burst_gap%0d", i), hs_t[i] - hs_t[i-1], 2);

        // Fill under backpressure: 4 queued plus 1 held
        bus.rsp_ready = 0;
        for (int i = 0; i < 5; i++) send(8'(i * 16 + 1), 8'(i + 3), 4'(i));
        first = ref_rsp(8'h01, 8'h03, 4'd0);
        bus.cmd_a = 8'hC3;
        bus.cmd_b = 8'h3C;
        bus.cmd_op = 4'd4;
        bus.cmd_valid = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("fill_ready_low%0d", i), 32'(bus.cmd_ready), 0);
            chk($sformatf("fill_y%0d", i), 32'(bus.rsp_y), 32'(first.y));
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("fill_sixth_accept", 32'(bus.cmd_ready), 1);
        @(posedge clk);
        #1 bus.cmd_valid = 0;
        drain(100);

        // Random traffic with random backpressure, counted from a fresh reset
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        rnd_on = 1;
        fork
            begin
                for (int i = 0; i < 20; i++) send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 10)));
                drain(400);
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1 bus.rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.rsp_ready = 1;
        @(negedge clk);
        chk("rnd_done_cnt", 32'(done_cnt), 20);
        @(posedge clk);
        #1;

        // Stream illegal ops at one handshake per clock until done_cnt wraps
        bus.cmd_a = 8'h5A;
        bus.cmd_b = 8'hA5;
        bus.cmd_op = 4'hC;
        bus.cmd_valid = 1;
        n = 0;
        k = 0;
        while (n < NW && k < NW + 100) begin
            @(negedge clk);
            k++;
            if (bus.cmd_ready) n++;
        end
        @(posedge clk);
        #1 bus.cmd_valid = 0;
        chk("wrap_accepts", n, NW);
        drain(100);
        @(negedge clk);
        chk("wrap_done_cnt", 32'(done_cnt), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
